// File: rtl/ct_ifu_spsram_256x23_ctrl.sv
// Arbiter/controller for a 256x23 single-port SRAM: one access per cycle,
// read-priority with write starvation relief, and a full-table init sweep.
module ct_ifu_spsram_256x23_ctrl #(
  parameter logic [22:0] INIT_VAL   = 23'h0,
  parameter int unsigned STARVE_MAX = 3
) (
  input  logic        forever_cpuclk,
  input  logic        cpurst,
  input  logic        rd_req,
  input  logic [7:0]  rd_addr,
  output logic        rd_gnt,
  output logic        rd_vld,
  output logic [22:0] rd_data,
  input  logic        wr_req,
  input  logic [7:0]  wr_addr,
  input  logic [22:0] wr_data,
  input  logic [22:0] wr_mask,
  output logic        wr_gnt,
  input  logic        inv_req,
  output logic        init_busy,
  output logic        sram_cen,
  output logic        sram_gwen,
  output logic [7:0]  sram_a,
  output logic [22:0] sram_d,
  output logic [22:0] sram_wen,
  input  logic [22:0] sram_q
);

  localparam int unsigned SW = (STARVE_MAX < 3) ? 2 : $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

  typedef enum logic {ST_INIT, ST_RUN} state_e;

  state_e        state_q, state_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [SW-1:0] starve_q, starve_d;
  logic          rd_vld_q;
  logic          force_wr;

  always_ff @(posedge forever_cpuclk or posedge cpurst) begin
    if (cpurst) begin
      state_q  <= ST_INIT;
      cnt_q    <= '0;
      starve_q <= '0;
      rd_vld_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      starve_q <= starve_d;
      rd_vld_q <= rd_gnt;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    force_wr  = 1'b0;
    rd_gnt    = 1'b0;
    wr_gnt    = 1'b0;
    init_busy = (state_q == ST_INIT);
    sram_cen  = 1'b1;
    sram_gwen = 1'b1;
    sram_wen  = '1;
    sram_a    = '0;
    sram_d    = '0;
    case (state_q)
      ST_INIT: begin
        // The SRAM port stays idle while reset is held, even though the state is INIT.
        if (!cpurst) begin
          sram_cen  = 1'b0;
          sram_gwen = 1'b0;
          sram_wen  = '0;
          sram_a    = cnt_q;
          sram_d    = INIT_VAL;
        end
        cnt_d = cnt_q + 8'd1;
        if (cnt_q == 8'hFF) state_d = ST_RUN;
      end
      ST_RUN: begin
        force_wr = wr_req && (starve_q == STARVE_LIM);
        wr_gnt   = wr_req && (!rd_req || force_wr);
        rd_gnt   = rd_req && !force_wr;
        if (wr_gnt) begin
          sram_cen  = 1'b0;
          sram_gwen = 1'b0;
          sram_wen  = ~wr_mask;
          sram_a    = wr_addr;
          sram_d    = wr_data;
        end else if (rd_gnt) begin
          sram_cen  = 1'b0;
          sram_a    = rd_addr;
        end
        if (inv_req) begin
          state_d = ST_INIT;
          cnt_d   = '0;
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  always_comb begin
    starve_d = '0;
    if (wr_req && !wr_gnt)
      starve_d = (starve_q == STARVE_LIM) ? starve_q : starve_q + 1'b1;
  end

  assign rd_vld  = rd_vld_q;
  assign rd_data = sram_q;

endmodule

// File: tb/tb_ct_ifu_spsram_256x23_ctrl.sv
// Randomized scoreboard bench for ct_ifu_spsram_256x23_ctrl with a behavioural SRAM
// and an array-based reference model of table contents and arbitration.
module tb_ct_ifu_spsram_256x23_ctrl;

  localparam logic [22:0] INIT_VAL   = 23'h155;
  localparam int          STARVE_MAX = 3;

  logic        clk, cpurst;
  logic        rd_req, rd_gnt, rd_vld;
  logic [7:0]  rd_addr;
  logic [22:0] rd_data;
  logic        wr_req, wr_gnt;
  logic [7:0]  wr_addr;
  logic [22:0] wr_data, wr_mask;
  logic        inv_req, init_busy;
  logic        sram_cen, sram_gwen;
  logic [7:0]  sram_a;
  logic [22:0] sram_d, sram_wen, sram_q;

  ct_ifu_spsram_256x23_ctrl #(.INIT_VAL(INIT_VAL), .STARVE_MAX(STARVE_MAX)) dut (
    .forever_cpuclk(clk), .cpurst(cpurst),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt), .rd_vld(rd_vld), .rd_data(rd_data),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_mask(wr_mask), .wr_gnt(wr_gnt),
    .inv_req(inv_req), .init_busy(init_busy),
    .sram_cen(sram_cen), .sram_gwen(sram_gwen), .sram_a(sram_a), .sram_d(sram_d),
    .sram_wen(sram_wen), .sram_q(sram_q)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural single-port SRAM with registered read data.
  logic [22:0] sram_mem [256];
  always @(posedge clk) begin
    if (!sram_cen) begin
      if (sram_gwen) sram_q <= sram_mem[sram_a];
      else sram_mem[sram_a] <= (sram_mem[sram_a] & sram_wen) | (sram_d & ~sram_wen);
    end
  end

  // Reference model state
  logic [22:0] ref_mem [256];
  logic [22:0] exp_q [$];
  int          init_left;
  int          starve;
  bit          exp_vld;
  bit          rel_pending;
  int          compared, mismatched;

  // Requester state
  bit          rd_pend, wr_pend, inv_drv;
  logic [7:0]  rd_a, wr_a;
  logic [22:0] wr_d, wr_m;
  int          addr_hi;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic evaluate();
    bit erg, ewg, fw;
    logic [22:0] exp_wen;
    int idx;
    erg = 1'b0;
    ewg = 1'b0;
    check("rd_vld", {31'd0, rd_vld}, {31'd0, exp_vld});
    if (init_left > 0) begin
      idx = 256 - init_left;
      check("init_busy", {31'd0, init_busy}, 32'd1);
      check("init_rd_gnt", {31'd0, rd_gnt}, 32'd0);
      check("init_wr_gnt", {31'd0, wr_gnt}, 32'd0);
      check("init_cen", {31'd0, sram_cen}, 32'd0);
      check("init_gwen", {31'd0, sram_gwen}, 32'd0);
      check("init_addr", {24'd0, sram_a}, 32'(idx));
      check("init_data", {9'd0, sram_d}, {9'd0, INIT_VAL});
      check("init_wen", {9'd0, sram_wen}, 32'd0);
      ref_mem[idx] = INIT_VAL;
      init_left--;
    end else begin
      fw  = wr_pend && (starve == STARVE_MAX);
      ewg = wr_pend && (!rd_pend || fw);
      erg = rd_pend && !fw;
      check("run_busy", {31'd0, init_busy}, 32'd0);
      check("rd_gnt", {31'd0, rd_gnt}, {31'd0, erg});
      check("wr_gnt", {31'd0, wr_gnt}, {31'd0, ewg});
      check("sram_cen", {31'd0, sram_cen}, {31'd0, !(ewg || erg)});
      if (ewg) begin
        exp_wen = ~wr_m;
        check("wr_addr", {24'd0, sram_a}, {24'd0, wr_a});
        check("wr_wen", {9'd0, sram_wen}, {9'd0, exp_wen});
        check("wr_gwen", {31'd0, sram_gwen}, 32'd0);
        ref_mem[wr_a] = (ref_mem[wr_a] & ~wr_m) | (wr_d & wr_m);
      end
      if (erg) begin
        check("rd_addr", {24'd0, sram_a}, {24'd0, rd_a});
        check("rd_gwen", {31'd0, sram_gwen}, 32'd1);
        exp_q.push_back(ref_mem[rd_a]);
      end
      if (inv_drv) init_left = 256;
    end
    if (wr_pend && !ewg) starve = (starve < STARVE_MAX) ? starve + 1 : STARVE_MAX;
    else starve = 0;
    exp_vld = erg;
    if (ewg) wr_pend = 1'b0;
    if (erg) rd_pend = 1'b0;
  endtask

  task automatic run(input int n, input int prd, input int pwr, input int pinv);
    for (int c = 0; c < n; c++) begin
      @(posedge clk); #1;
      if (rel_pending) begin
        cpurst = 1'b0;
        rel_pending = 1'b0;
      end
      if (!rd_pend && ($urandom_range(99) < prd)) begin
        rd_pend = 1'b1;
        rd_a = 8'($urandom_range(addr_hi));
      end
      if (!wr_pend && ($urandom_range(99) < pwr)) begin
        wr_pend = 1'b1;
        wr_a = 8'($urandom_range(addr_hi));
        wr_d = 23'($urandom);
        wr_m = 23'($urandom);
      end
      inv_drv = ($urandom_range(99) < pinv);
      rd_req  = rd_pend;
      rd_addr = rd_pend ? rd_a : 8'($urandom);
      wr_req  = wr_pend;
      wr_addr = wr_pend ? wr_a : 8'($urandom);
      wr_data = wr_pend ? wr_d : 23'($urandom);
      wr_mask = wr_pend ? wr_m : 23'($urandom);
      inv_req = inv_drv;
      #2;
      evaluate();
    end
  endtask

  task automatic reset_pulse(input int n);
    @(posedge clk); #1;
    cpurst = 1'b1;
    rd_req = 1'b0; wr_req = 1'b0; inv_req = 1'b0;
    rd_pend = 1'b0; wr_pend = 1'b0; inv_drv = 1'b0;
    exp_q.delete();
    init_left = 256;
    starve = 0;
    exp_vld = 1'b0;
    #1;
    check("rst_rd_vld", {31'd0, rd_vld}, 32'd0);
    check("rst_rd_gnt", {31'd0, rd_gnt}, 32'd0);
    check("rst_wr_gnt", {31'd0, wr_gnt}, 32'd0);
    check("rst_busy", {31'd0, init_busy}, 32'd1);
    check("rst_cen", {31'd0, sram_cen}, 32'd1);
    check("rst_gwen", {31'd0, sram_gwen}, 32'd1);
    check("rst_wen", {9'd0, sram_wen}, 32'h7FFFFF);
    repeat (n) @(posedge clk);
    rel_pending = 1'b1;
  endtask

  always @(negedge clk) begin
    if (!cpurst && rd_vld) begin
      if (exp_q.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL rd_data: rd_vld=1 got %0h expected no read outstanding at %0t", rd_data, $time);
      end else begin
        check("rd_data", {9'd0, rd_data}, {9'd0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    cpurst = 1'b1;
    rd_req = 1'b0; rd_addr = '0;
    wr_req = 1'b0; wr_addr = '0; wr_data = '0; wr_mask = '0;
    inv_req = 1'b0;
    compared = 0; mismatched = 0;
    rd_pend = 1'b0; wr_pend = 1'b0; inv_drv = 1'b0;
    rd_a = '0; wr_a = '0; wr_d = '0; wr_m = '0;
    addr_hi = 255;
    rel_pending = 1'b0;
    exp_vld = 1'b0;
    starve = 0;
    init_left = 256;
    for (int i = 0; i < 256; i++) begin
      sram_mem[i] = 23'($urandom);
      ref_mem[i]  = 23'($urandom);
    end

    // Power-up sweep with requests arriving during it (never granted until RUN)
    reset_pulse(3);
    run(256, 50, 50, 0);
    run(4, 0, 0, 0);

    // Table boundaries after the sweep
    rd_pend = 1'b1; rd_a = 8'h00; run(2, 0, 0, 0);
    rd_pend = 1'b1; rd_a = 8'hFF; run(2, 0, 0, 0);

    // Masked write then read-back of the same entry
    wr_pend = 1'b1; wr_a = 8'h10; wr_d = 23'h7FFFFF; wr_m = 23'h0000FF;
    run(1, 0, 0, 0);
    rd_pend = 1'b1; rd_a = 8'h10; run(3, 0, 0, 0);

    // Random traffic over a narrow address range to exercise read-after-write
    addr_hi = 15;
    run(400, 60, 60, 0);

    // Both requesters saturated: starvation relief pattern
    run(24, 100, 100, 0);
    run(4, 0, 0, 0);

    // Invalidate coinciding with a granted write
    wr_pend = 1'b1; wr_a = 8'h20; wr_d = 23'($urandom); wr_m = '1;
    run(1, 0, 0, 100);
    run(256, 40, 40, 0);
    run(4, 0, 0, 0);
    rd_pend = 1'b1; rd_a = 8'h20; run(3, 0, 0, 0);

    // Reset in the middle of a sweep
    run(1, 0, 0, 100);
    run(100, 0, 0, 0);
    reset_pulse(2);
    run(260, 30, 30, 0);

    // Reset while a read result is pending
    rd_pend = 1'b1; rd_a = 8'h03; run(1, 0, 0, 0);
    reset_pulse(1);
    run(260, 30, 30, 0);

    // Long random run with occasional invalidates
    run(2000, 50, 50, 1);

    for (int k = 0; k < 400 && (rd_pend || wr_pend || init_left > 0); k++) run(1, 0, 0, 0);
    run(3, 0, 0, 0);
    check("drain", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
